spi_flash_writer: RTL and testbench
===================================

SPI_FLASH_WRITER -- requirements
Module: spi_flash_writer

Interface
REQ-001 Parameter POLL_LIMIT, default 24'hFFFFFF: maximum number of status bytes read per poll before timeout.
REQ-002 Parameter CS_GAP, default 4: minimum number of clk cycles cs is held high between flash transactions.
REQ-003 clk  input  1  system clock, 27 MHz; the block has one clock only.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 write  input  1  one-cycle request to program one byte; sampled only in IDLE.
REQ-006 erase  input  1  one-cycle request to erase the 4 KiB sector containing addr; sampled only in IDLE.
REQ-007 addr  input  24  flash byte address; captured on request.
REQ-008 data  input  8  byte to program; captured on request.
REQ-009 busy  output  1  high from the request-accept cycle until done.
REQ-010 done  output  1  one-cycle pulse when the operation completes.
REQ-011 err  output  1  valid with done; 1 means status-poll timeout.
REQ-012 sclk  output  1  SPI clock, registered, idle low (mode 0).
REQ-013 cs  output  1  flash chip select, active low, idle high.
REQ-014 mosi  output  1  serial data to the flash DI pin.
REQ-015 miso  input  1  serial data from the flash DO pin.

Function
REQ-016 SPI bit timing: each bit takes 2 clk cycles (sclk = clk/2), with sclk low in the first cycle and high in the second.
REQ-017 mosi changes only on the clk edge that drives sclk low; the first bit is driven in the cycle after cs falls; MSB first.
REQ-018 miso is sampled on the clk edge that drives sclk from high to low.
REQ-019 FSM states: IDLE, WREN, GAP1, OP, GAP2, POLL, DONE.
REQ-020 IDLE: if write or erase is high, capture addr/data/op, set busy, drop cs, and go to WREN; if both are high, erase wins.
REQ-021 WREN: shift opcode 8'h06 (8 bits), then raise cs and go to GAP1.
REQ-022 GAP1 and GAP2: hold cs high for CS_GAP cycles; GAP1 goes to OP, GAP2 goes to POLL.
REQ-023 OP for program: shift 8'h02, addr[23:0], data[7:0] (40 bits), then raise cs and go to GAP2.
REQ-024 OP for erase: shift 8'h20 and addr[23:0] (32 bits), then raise cs and go to GAP2.
REQ-025 POLL: drop cs, shift 8'h05, then keep cs low and read status bytes continuously.
REQ-026 POLL exit on success: after each complete status byte, if bit0 (WIP) == 0, raise cs and go to DONE with err=0.
REQ-027 POLL exit on timeout: if the status-byte count reaches POLL_LIMIT with WIP still 1, raise cs and go to DONE with err=1.
REQ-028 DONE: pulse done for 1 cycle, clear busy, return to IDLE; sclk is low and cs is high.
REQ-029 Requests arriving while busy are ignored and not queued.
REQ-030 A new request in the cycle after done is accepted.
REQ-031 mosi is a don't-care but is driven 1 whenever not shifting command, address or data bits.
REQ-032 The status-byte counter is 24 bits and saturates; it never wraps.

Reset
REQ-033 On rst: state=IDLE, cs=1, sclk=0, mosi=1, busy=0, done=0, err=0, all counters and shift registers cleared.
REQ-034 rst asserted mid-transaction aborts at once: cs rises asynchronously and no done pulse is issued.
REQ-035 After rst is released, the first request is accepted on the next edge in IDLE.

Structure
REQ-036 Opcodes (06/02/20/05), the WIP bit index and FSM state encodings are defined in a shared package spi_flash_pkg.
REQ-037 One sub-module, spi_shift_engine, contains the clk/2 sclk generator, the 40-bit MSB-first shifter, the 8-bit receive shifter and the bit counter, with start/len/busy/byte_done handshake.
REQ-038 All outputs are registered; there are no combinational paths from inputs to outputs.

Verification
REQ-039 Program: write=1 with addr=24'h400010, data=8'hA5, flash model WIP=1 for 3 status bytes -> mosi shows 06 | 02 40 00 10 A5 | 05; done after the 4th status byte; err=0.
REQ-040 Erase: erase=1 with addr=24'h401234 -> OP shifts 20 40 12 34 (32 bits); gaps between transactions are >= 4 cycles with cs high; done with err=0.
REQ-041 Timeout: POLL_LIMIT=5 and WIP held at 1 -> exactly 5 status bytes are read, then done with err=1.
REQ-042 Collision: write and erase both high in the same cycle -> an erase sequence is issued; a write pulse while busy -> no extra transaction.
REQ-043 Reset mid-OP: rst asserted after 17 bits -> cs=1 within the same cycle, no done pulse, and the next write completes normally.
REQ-044 Timing check: sclk period is 2 clk cycles; mosi is stable across every sclk rising edge.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// ---------------------------------------------------------------------------
// spi_flash_pkg
// Purpose : shared definitions for the SPI flash writer: flash opcodes, the
//           status-register WIP bit index, FSM state encoding and a helper
//           that builds the program/erase command frame.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package spi_flash_pkg;

   localparam logic [7:0] OP_WREN = 8'h06;   // write enable
   localparam logic [7:0] OP_PP   = 8'h02;   // page program
   localparam logic [7:0] OP_SE   = 8'h20;   // 4 KiB sector erase
   localparam logic [7:0] OP_RDSR = 8'h05;   // read status register

   localparam int WIP_BIT = 0;               // write-in-progress status bit
   localparam int FRAME_W = 40;              // widest frame: opcode+addr+data

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WREN = 3'd1,
      ST_GAP1 = 3'd2,
      ST_OP   = 3'd3,
      ST_GAP2 = 3'd4,
      ST_POLL = 3'd5,
      ST_DONE = 3'd6
   } state_t;

   // Frame is MSB-aligned; an erase leaves the unused trailing byte at all
   // ones so the line idles high even if it were ever shifted.
   function automatic logic [FRAME_W-1:0] op_frame(input logic        is_erase,
                                                   input logic [23:0] a,
                                                   input logic [7:0]  d);
      if (is_erase) op_frame = {OP_SE, a, 8'hFF};
      else          op_frame = {OP_PP, a, d};
   endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// ---------------------------------------------------------------------------
// spi_shift_engine
// Purpose : mode-0 SPI bit engine. Generates sclk = clk/2 (low cycle then
//           high cycle), shifts up to 40 bits MSB first and collects the
//           received bits into an 8-bit shifter.
// Ports   : clk, rst          clock, asynchronous active-high reset
//           i_start, i_len    start a transfer of i_len bits (multiple of 8)
//           i_tx              MSB-aligned transmit frame
//           i_miso            serial input, sampled as sclk falls
//           o_busy            high while a transfer is in progress
//           o_byte_done       one-cycle pulse after every 8th bit
//           o_rx              last 8 received bits
//           o_sclk, o_mosi    registered SPI clock and serial output
// ---------------------------------------------------------------------------
module spi_shift_engine
   import spi_flash_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [5:0]         i_len,
   input  logic [FRAME_W-1:0] i_tx,
   input  logic               i_miso,
   output logic               o_busy,
   output logic               o_byte_done,
   output logic [7:0]         o_rx,
   output logic               o_sclk,
   output logic               o_mosi
);

   logic [FRAME_W-1:0] r_sh;
   logic [5:0]         r_cnt;     // bits still to complete, current one included
   logic               r_busy;
   logic               r_sclk;
   logic               r_mosi;
   logic               r_bd;
   logic [7:0]         r_rx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh   <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_sclk <= 1'b0;
         r_mosi <= 1'b1;
         r_bd   <= 1'b0;
         r_rx   <= '0;
      end else begin
         r_bd <= 1'b0;
         if (!r_busy) begin
            // First bit goes out on the start edge, with sclk held low.
            if (i_start) begin
               r_busy <= 1'b1;
               r_sh   <= i_tx;
               r_cnt  <= i_len;
               r_mosi <= i_tx[FRAME_W-1];
               r_sclk <= 1'b0;
            end
         end else if (!r_sclk) begin
            r_sclk <= 1'b1;
         end else begin
            // Falling edge: sample miso, then either present the next bit
            // or finish and park mosi high.
            r_sclk <= 1'b0;
            r_rx   <= {r_rx[6:0], i_miso};
            if (r_cnt[2:0] == 3'd1) r_bd <= 1'b1;
            if (r_cnt == 6'd1) begin
               r_busy <= 1'b0;
               r_mosi <= 1'b1;
               r_cnt  <= '0;
            end else begin
               r_sh   <= {r_sh[FRAME_W-2:0], 1'b1};
               r_mosi <= r_sh[FRAME_W-2];
               r_cnt  <= r_cnt - 6'd1;
            end
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_byte_done = r_bd;
   assign o_rx        = r_rx;
   assign o_sclk      = r_sclk;
   assign o_mosi      = r_mosi;

endmodule

// File: rtl/spi_flash_writer.sv
// ---------------------------------------------------------------------------
// spi_flash_writer
// Purpose : programs one byte or erases one 4 KiB sector of a SPI NOR flash:
//           WREN, cs gap, PP/SE command, cs gap, then RDSR polling until WIP
//           clears or the poll limit is hit.
// Params  : POLL_LIMIT  max status bytes per poll before timeout
//           CS_GAP      min clk cycles cs stays high between transactions
// Ports   : clk, rst              clock, asynchronous active-high reset
//           write, erase          one-cycle requests (erase wins if both)
//           addr, data            captured on request
//           busy, done, err       status; err is valid with done
//           sclk, cs, mosi, miso  SPI mode-0 pins
// ---------------------------------------------------------------------------
module spi_flash_writer
   import spi_flash_pkg::*;
#(
   parameter logic [23:0] POLL_LIMIT = 24'hFFFFFF,
   parameter int          CS_GAP     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        write,
   input  logic        erase,
   input  logic [23:0] addr,
   input  logic [7:0]  data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        sclk,
   output logic        cs,
   output logic        mosi,
   input  logic        miso
);

   localparam logic [15:0] GAP_LAST = (CS_GAP > 1) ? 16'(CS_GAP - 1) : 16'd0;

   state_t      r_state;
   logic        r_erase;
   logic [23:0] r_addr;
   logic [7:0]  r_data;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic        r_cs;
   logic        r_issued;     // current engine transfer has been started
   logic        r_rdsr_sent;  // RDSR opcode is out, now reading status
   logic [15:0] r_gap;
   logic [23:0] r_pcnt;       // status bytes read in this poll

   logic               w_start;
   logic [5:0]         w_len;
   logic [FRAME_W-1:0] w_tx;
   logic               w_eng_busy;
   logic               w_byte_done;
   logic [7:0]         w_rx;
   logic               w_xfer_end;
   logic [23:0]        w_pcnt_inc;

   assign w_start    = !r_issued &&
                       (r_state == ST_WREN || r_state == ST_OP || r_state == ST_POLL);
   assign w_xfer_end = r_issued && !w_eng_busy;
   assign w_pcnt_inc = (r_pcnt == 24'hFFFFFF) ? r_pcnt : r_pcnt + 24'd1;

   always_comb begin
      w_tx  = '1;
      w_len = 6'd8;
      case (r_state)
         ST_WREN: w_tx = {OP_WREN, 32'hFFFF_FFFF};
         ST_OP: begin
            w_tx  = op_frame(r_erase, r_addr, r_data);
            w_len = r_erase ? 6'd32 : 6'd40;
         end
         ST_POLL: if (!r_rdsr_sent) w_tx = {OP_RDSR, 32'hFFFF_FFFF};
         default: ;
      endcase
   end

   spi_shift_engine u_eng (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_start),
      .i_len       (w_len),
      .i_tx        (w_tx),
      .i_miso      (miso),
      .o_busy      (w_eng_busy),
      .o_byte_done (w_byte_done),
      .o_rx        (w_rx),
      .o_sclk      (sclk),
      .o_mosi      (mosi)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_erase     <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_cs        <= 1'b1;
         r_issued    <= 1'b0;
         r_rdsr_sent <= 1'b0;
         r_gap       <= '0;
         r_pcnt      <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_start) r_issued <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (write || erase) begin
                  r_erase  <= erase;
                  r_addr   <= addr;
                  r_data   <= data;
                  r_busy   <= 1'b1;
                  r_err    <= 1'b0;
                  r_cs     <= 1'b0;
                  r_issued <= 1'b0;
                  r_state  <= ST_WREN;
               end
            end
            ST_WREN: begin
               if (w_xfer_end) begin
                  r_cs     <= 1'b1;
                  r_gap    <= '0;
                  r_issued <= 1'b0;
                  r_state  <= ST_GAP1;
               end
            end
            ST_GAP1: begin
               if (r_gap == GAP_LAST) begin
                  r_cs    <= 1'b0;
                  r_state <= ST_OP;
               end else begin
                  r_gap <= r_gap + 16'd1;
               end
            end
            ST_OP: begin
               if (w_xfer_end) begin
                  r_cs     <= 1'b1;
                  r_gap    <= '0;
                  r_issued <= 1'b0;
                  r_state  <= ST_GAP2;
               end
            end
            ST_GAP2: begin
               if (r_gap == GAP_LAST) begin
                  r_cs        <= 1'b0;
                  r_rdsr_sent <= 1'b0;
                  r_pcnt      <= '0;
                  r_state     <= ST_POLL;
               end else begin
                  r_gap <= r_gap + 16'd1;
               end
            end
            ST_POLL: begin
               if (w_xfer_end) begin
                  if (!r_rdsr_sent) begin
                     r_rdsr_sent <= 1'b1;
                     r_issued    <= 1'b0;
                  end else if (w_byte_done) begin
                     r_pcnt <= w_pcnt_inc;
                     if (!w_rx[WIP_BIT]) begin
                        r_cs    <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= ST_DONE;
                     end else if (w_pcnt_inc >= POLL_LIMIT) begin
                        r_cs    <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                     end else begin
                        // cs stays low; the next status byte follows.
                        r_issued <= 1'b0;
                     end
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;
   assign cs   = r_cs;

endmodule

// File: tb/tb_spi_flash_writer.sv
module tb_spi_flash_writer;

   localparam logic [23:0] LIMIT = 24'd5;

   logic        clk = 1'b0;
   logic        rst;
   logic        write;
   logic        erase;
   logic [23:0] addr;
   logic [7:0]  data;
   logic        busy;
   logic        done;
   logic        err;
   logic        sclk;
   logic        cs;
   logic        mosi;
   logic        miso;

   always #5 clk = ~clk;

   spi_flash_writer #(.POLL_LIMIT(LIMIT), .CS_GAP(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .write(write),
      .erase(erase),
      .addr (addr),
      .data (data),
      .busy (busy),
      .done (done),
      .err  (err),
      .sclk (sclk),
      .cs   (cs),
      .mosi (mosi),
      .miso (miso)
   );

   // ------------------------------------------------------------------
   // Bus monitor and flash model (evaluated on the falling clk edge)
   // ------------------------------------------------------------------
   typedef struct {
      int          nbits;
      logic [7:0]  first;
      logic [39:0] val;
   } tr_t;

   tr_t         trq[$];
   logic        p_sclk = 1'b0;
   logic        p_cs   = 1'b1;
   logic        p_mosi = 1'b1;
   int          cur_rise = 0;
   int          cur_fall = 0;
   logic [7:0]  cur_first = 8'h00;
   logic [39:0] cur_val = 40'h0;
   int          gap_cnt = 0;
   int          min_gap = 1000;
   int          done_cnt = 0;
   int          tmg_err = 0;
   int          wip_n = 0;
   int          k;
   logic [7:0]  sb;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (!p_sclk && sclk && (mosi !== p_mosi)) tmg_err++;   // mosi moved at rising sclk
      if (p_sclk && sclk) tmg_err++;                         // sclk high longer than 1 clk
      if (cs && (mosi !== 1'b1)) tmg_err++;                  // idle mosi must be 1
      if (p_cs && !cs) begin
         if (trq.size() > 0 && gap_cnt < min_gap) min_gap = gap_cnt;
         cur_rise  = 0;
         cur_fall  = 0;
         cur_val   = 40'h0;
         cur_first = 8'h00;
      end
      if (!p_cs && cs) begin
         trq.push_back('{cur_rise, cur_first, cur_val});
         gap_cnt = 0;
      end
      if (cs) gap_cnt++;
      if (!cs && !p_sclk && sclk) begin
         cur_rise++;
         if (cur_rise <= 40) cur_val = {cur_val[38:0], mosi};
         if (cur_rise == 8) cur_first = cur_val[7:0];
      end
      if (!cs && p_sclk && !sclk) begin
         cur_fall++;
         if (cur_first == 8'h05 && cur_fall >= 8) begin
            k  = cur_fall - 8;
            sb = ((k / 8) < wip_n) ? 8'h03 : 8'h02;
            miso = sb[7 - (k % 8)];
         end
      end
      p_sclk = sclk;
      p_cs   = cs;
      p_mosi = mosi;
   end

   // ------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        w;
      logic        e;
      logic [23:0] a;
      logic [7:0]  d;
      int          wip;       // status bytes reporting WIP=1
      logic        poke;      // extra write pulse while busy
      int          exp_bits;  // bits in the PP/SE transaction
      logic [39:0] exp_val;
      int          exp_stat;  // status bytes read
      logic        exp_err;
   } vec_t;

   // Issues one request and waits for done; returns with monitor settled.
   task automatic run_op(input vec_t v, output logic got_done, output logic got_err,
                         output logic busy_acc, output logic busy_at_done);
      trq.delete();
      min_gap = 1000;
      wip_n   = v.wip;
      got_done = 1'b0;
      got_err  = 1'b0;
      busy_at_done = 1'b1;
      @(negedge clk);
      write = v.w; erase = v.e; addr = v.a; data = v.d;
      @(negedge clk);
      write = 1'b0; erase = 1'b0;
      busy_acc = busy;
      for (int c = 0; c < 3000 && !got_done; c++) begin
         write = v.poke && (c == 40);
         @(negedge clk);
         if (done === 1'b1) begin
            got_done = 1'b1;
            got_err  = err;
            busy_at_done = busy;
         end
      end
      write = 1'b0;
      #1;
   endtask

   vec_t vecs[6];
   logic g_done, g_err, g_bacc, g_bdone;
   int   dc0;
   int   sz;
   logic hit;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 24'h400010, 8'hA5, 3,    1'b1, 40, 40'h02400010A5, 4, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 24'h401234, 8'h00, 2,    1'b0, 32, 40'h0020401234, 3, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 24'h123456, 8'h77, 0,    1'b0, 32, 40'h0020123456, 1, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 24'hFFFFFF, 8'h00, 1,    1'b0, 40, 40'h02FFFFFF00, 2, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 24'h000000, 8'hFF, 1000, 1'b0, 40, 40'h02000000FF, 5, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 24'h000FFF, 8'h00, 4,    1'b0, 32, 40'h0020000FFF, 5, 1'b0};

      rst = 1'b1; write = 1'b0; erase = 1'b0; addr = '0; data = '0; miso = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset cs",   64'(cs),   64'd1);
      chk("reset sclk", 64'(sclk), 64'd0);
      chk("reset mosi", 64'(mosi), 64'd1);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset err",  64'(err),  64'd0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i], g_done, g_err, g_bacc, g_bdone);
         chk($sformatf("v%0d busy on accept", i), 64'(g_bacc), 64'd1);
         chk($sformatf("v%0d done seen", i), 64'(g_done), 64'd1);
         chk($sformatf("v%0d err", i), 64'(g_err), 64'(vecs[i].exp_err));
         chk($sformatf("v%0d busy at done", i), 64'(g_bdone), 64'd0);
         sz = trq.size();
         chk($sformatf("v%0d transactions", i), 64'(sz), 64'd3);
         if (sz == 3) begin
            chk($sformatf("v%0d wren bits", i), 64'(trq[0].nbits), 64'd8);
            chk($sformatf("v%0d wren opcode", i), 64'(trq[0].first), 64'h06);
            chk($sformatf("v%0d op bits", i), 64'(trq[1].nbits), 64'(vecs[i].exp_bits));
            chk($sformatf("v%0d op frame", i), 64'(trq[1].val), 64'(vecs[i].exp_val));
            chk($sformatf("v%0d poll opcode", i), 64'(trq[2].first), 64'h05);
            chk($sformatf("v%0d status bytes", i), 64'((trq[2].nbits - 8) / 8),
                64'(vecs[i].exp_stat));
         end
         chk($sformatf("v%0d cs gap>=4", i), 64'(min_gap >= 4 && min_gap < 1000), 64'd1);
         if (vecs[i].poke) begin
            repeat (30) @(negedge clk);
            #1;
            chk("busy poke no extra txn", 64'(trq.size()), 64'd3);
            chk("busy poke idle", 64'(busy), 64'd0);
         end
      end

      // Reset in the middle of the program command, after 17 bits.
      trq.delete();
      wip_n = 0;
      @(negedge clk);
      write = 1'b1; addr = 24'h400010; data = 8'hA5;
      @(negedge clk);
      write = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 500 && !hit; c++) begin
         @(negedge clk);
         #1;
         if (trq.size() == 1 && cur_rise == 17) hit = 1'b1;
      end
      chk("reached 17 op bits", 64'(hit), 64'd1);
      dc0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("rst cs async", 64'(cs),   64'd1);
      chk("rst busy",     64'(busy), 64'd0);
      chk("rst sclk",     64'(sclk), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("no done after rst", 64'(done_cnt - dc0), 64'd0);
      run_op(vecs[3], g_done, g_err, g_bacc, g_bdone);
      chk("post-rst done", 64'(g_done), 64'd1);
      chk("post-rst err",  64'(g_err),  64'd0);
      if (trq.size() == 3)
         chk("post-rst op frame", 64'(trq[1].val), 64'(vecs[3].exp_val));
      else
         chk("post-rst transactions", 64'(trq.size()), 64'd3);

      repeat (5) @(negedge clk);
      chk("sclk/mosi timing violations", 64'(tmg_err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
